// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC output formatter: ramp states,
// midscale code and the window-shift clamp.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    // Code that puts the DAC at zero output; caller truncates to OUT_WIDTH.
    function automatic logic [31:0] midscale(input int ow, input bit ob);
        if (ob) return 32'd1 << (ow - 1);
        return 32'd0;
    endfunction

    function automatic int clamp_shift(input logic [7:0] sh, input int lo, input int hi);
        int s;
        s = int'(sh);
        if (s < lo) return lo;
        if (s > hi) return hi;
        return s;
    endfunction

endpackage

// File: rtl/dac_out_ramp_if.sv
// Sample/control bundle between the TX DSP chain and the DAC formatter.
interface dac_out_ramp_if #(
    parameter int IN_WIDTH  = 27,
    parameter int OUT_WIDTH = 14
);
    logic                        tx;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  data_in;
    logic [7:0]                  shift;
    logic                        sat_clr;
    logic [OUT_WIDTH-1:0]        data_out;
    logic                        out_valid;
    logic                        tx_active;
    logic                        ramp_busy;
    logic                        sat_flag;

    modport master (
        output tx, in_valid, data_in, shift, sat_clr,
        input  data_out, out_valid, tx_active, ramp_busy, sat_flag
    );

    modport slave (
        input  tx, in_valid, data_in, shift, sat_clr,
        output data_out, out_valid, tx_active, ramp_busy, sat_flag
    );
endinterface

// File: rtl/dac_sat_round.sv
// Window select with round-half-up and saturation of a wide signed sample
// down to OUT_WIDTH bits; purely combinational.
module dac_sat_round
    import dac_pkg::*;
#(
    parameter int IN_WIDTH  = 27,
    parameter int OUT_WIDTH = 14
) (
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic [7:0]                  i_shift,
    output logic signed [OUT_WIDTH-1:0] o_win,
    output logic                        o_sat
);
    localparam logic signed [OUT_WIDTH-1:0] W_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] W_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    int                          w_s;
    logic [OUT_WIDTH:0]          w_win;
    logic signed [OUT_WIDTH:0]   w_rnd;
    logic                        w_oob;
    logic                        w_ovf;

    always_comb begin
        w_s   = clamp_shift(i_shift, OUT_WIDTH, IN_WIDTH);
        // Appended zero makes bit 0 the round bit, and 0 when s == OUT_WIDTH.
        w_win = (OUT_WIDTH+1)'({i_data, 1'b0} >> (w_s - OUT_WIDTH));
        w_oob = 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i >= w_s - 1 && i_data[i] != i_data[IN_WIDTH-1]) w_oob = 1'b1;
        end
        w_rnd = {w_win[OUT_WIDTH], w_win[OUT_WIDTH:1]} + {{OUT_WIDTH{1'b0}}, w_win[0]};
        w_ovf = w_rnd[OUT_WIDTH] != w_rnd[OUT_WIDTH-1];
        o_sat = w_oob | w_ovf;
        if (w_oob)      o_win = i_data[IN_WIDTH-1] ? W_MIN : W_MAX;
        else if (w_ovf) o_win = W_MAX;
        else            o_win = w_rnd[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/dac_out_ramp.sv
// DAC output formatter: window/saturate, soft-keying gain ramp and code
// formatting in a 3-stage pipeline; midscale when idle.
module dac_out_ramp
    import dac_pkg::*;
#(
    parameter int IN_WIDTH      = 27,
    parameter int OUT_WIDTH     = 14,
    parameter int RAMP_BITS     = 8,
    parameter int OFFSET_BINARY = 1
) (
    input  logic           clk_in,
    input  logic           reset,
    dac_out_ramp_if.slave  bus
);
    localparam int STAGES = 3;
    localparam int PW     = OUT_WIDTH + RAMP_BITS + 2;
    localparam logic [OUT_WIDTH-1:0] MID    = OUT_WIDTH'(midscale(OUT_WIDTH, OFFSET_BINARY != 0));
    localparam logic [RAMP_BITS:0]   G_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [RAMP_BITS:0]   G_ONE  = {{RAMP_BITS{1'b0}}, 1'b1};

    ramp_state_t                  r_state, w_state_nxt;
    logic [RAMP_BITS:0]           r_gain, w_gain_nxt;
    logic [STAGES:1]              r_vld_pipe;
    logic signed [OUT_WIDTH-1:0]  w_win;
    logic                         w_sat;
    logic signed [OUT_WIDTH-1:0]  r_s1_w;
    logic [RAMP_BITS:0]           r_s1_g;
    logic                         r_s1_idle;
    logic signed [OUT_WIDTH-1:0]  r_s2_p;
    logic                         r_s2_idle;
    logic [OUT_WIDTH-1:0]         r_dout;
    logic [OUT_WIDTH-1:0]         w_fmt;
    logic signed [PW-1:0]         w_mul_a, w_mul_b;
    logic                         r_tx_active, r_ramp_busy, r_sat_flag;

    dac_sat_round #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat (
        .i_data  (bus.data_in),
        .i_shift (bus.shift),
        .o_win   (w_win),
        .o_sat   (w_sat)
    );

    // Gain only ever moves by one step, so tx toggling reverses the ramp smoothly.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        if (bus.in_valid) begin
            if (bus.tx) w_gain_nxt = (r_gain == G_FULL) ? G_FULL : r_gain + G_ONE;
            else        w_gain_nxt = (r_gain == '0) ? '0 : r_gain - G_ONE;
            if (w_gain_nxt == '0)          w_state_nxt = IDLE;
            else if (w_gain_nxt == G_FULL) w_state_nxt = ON;
            else                           w_state_nxt = bus.tx ? RAMP_UP : RAMP_DOWN;
        end
    end

    assign w_mul_a = {{(PW-OUT_WIDTH){r_s1_w[OUT_WIDTH-1]}}, r_s1_w};
    assign w_mul_b = {{(PW-RAMP_BITS-1){1'b0}}, r_s1_g};
    assign w_fmt   = (OFFSET_BINARY != 0) ? {~r_s2_p[OUT_WIDTH-1], r_s2_p[OUT_WIDTH-2:0]}
                                          : r_s2_p;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gain      <= '0;
            r_vld_pipe  <= '0;
            r_s1_w      <= '0;
            r_s1_g      <= '0;
            r_s1_idle   <= 1'b1;
            r_s2_p      <= '0;
            r_s2_idle   <= 1'b1;
            r_dout      <= MID;
            r_tx_active <= 1'b0;
            r_ramp_busy <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gain      <= w_gain_nxt;
            r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
            r_tx_active <= (w_state_nxt != IDLE);
            r_ramp_busy <= (w_state_nxt == RAMP_UP) || (w_state_nxt == RAMP_DOWN);
            if (bus.in_valid) begin
                r_s1_w    <= w_win;
                r_s1_g    <= r_gain;
                r_s1_idle <= (r_state == IDLE);
            end
            if (r_vld_pipe[1]) begin
                r_s2_p    <= OUT_WIDTH'((w_mul_a * w_mul_b) >>> RAMP_BITS);
                r_s2_idle <= r_s1_idle;
            end
            if (r_vld_pipe[2]) r_dout <= r_s2_idle ? MID : w_fmt;
            if (bus.in_valid && w_sat && r_state != IDLE) r_sat_flag <= 1'b1;
            else if (bus.sat_clr)                          r_sat_flag <= 1'b0;
        end
    end

    assign bus.data_out  = r_dout;
    assign bus.out_valid = r_vld_pipe[STAGES];
    assign bus.tx_active = r_tx_active;
    assign bus.ramp_busy = r_ramp_busy;
    assign bus.sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_dac_out_ramp.sv
// Directed bench for dac_out_ramp with RAMP_BITS=4 (full ramp = 16 samples).
module tb_dac_out_ramp;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    dac_out_ramp_if #(.IN_WIDTH(27), .OUT_WIDTH(14)) bus ();

    dac_out_ramp #(.IN_WIDTH(27), .OUT_WIDTH(14), .RAMP_BITS(4), .OFFSET_BINARY(1)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.tx = 1'b0;
        bus.in_valid = 1'b0;
        bus.sat_clr = 1'b0;
        step;
        step;
        reset = 1'b0;
    endtask

    // One valid sample, then wait out the pipeline so data_out shows it.
    task automatic run_one(input logic signed [26:0] d, input logic [7:0] sh);
        bus.data_in = d;
        bus.shift = sh;
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        step;
        step;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (bus.data_out !== 14'h2000) begin bad++; $display("FAIL rst_dout: got %h want 2000", bus.data_out); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", bus.out_valid); end
        total++; if (bus.tx_active !== 1'b0) begin bad++; $display("FAIL rst_txa: got %b want 0", bus.tx_active); end
        // Saturating sample while idle must not raise the flag.
        bus.data_in = 27'sh0080000; bus.shift = 8'd20; bus.in_valid = 1'b1;
        step;
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL idle_sat: got %b want 0", bus.sat_flag); end
        bus.tx = 1'b1; bus.data_in = 27'sh0400000; bus.shift = 8'd27;
        repeat (6) step;
        total++; if (bus.ramp_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", bus.ramp_busy); end
        total++; if (bus.data_out !== 14'h2060) begin bad++; $display("FAIL mid_dout: got %h want 2060", bus.data_out); end
        reset = 1'b1;
        step;
        total++; if (bus.data_out !== 14'h2000) begin bad++; $display("FAIL rst2_dout: got %h want 2000", bus.data_out); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst2_vld: got %b want 0", bus.out_valid); end
        total++; if (bus.tx_active !== 1'b0) begin bad++; $display("FAIL rst2_txa: got %b want 0", bus.tx_active); end
        total++; if (bus.ramp_busy !== 1'b0) begin bad++; $display("FAIL rst2_busy: got %b want 0", bus.ramp_busy); end
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL rst2_sat: got %b want 0", bus.sat_flag); end
        reset = 1'b0; bus.tx = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_latency;
        do_reset;
        bus.tx = 1'b1; bus.in_valid = 1'b1; bus.data_in = '0; bus.shift = 8'd27;
        repeat (20) step;
        bus.in_valid = 1'b0;
        repeat (4) step;
        total++; if (bus.tx_active !== 1'b1) begin bad++; $display("FAIL on_txa: got %b want 1", bus.tx_active); end
        total++; if (bus.ramp_busy !== 1'b0) begin bad++; $display("FAIL on_busy: got %b want 0", bus.ramp_busy); end
        bus.data_in = 27'sh0400000; bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat1: got %b want 0", bus.out_valid); end
        step;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat2: got %b want 0", bus.out_valid); end
        step;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lat3: got %b want 1", bus.out_valid); end
        total++; if (bus.data_out !== 14'h2200) begin bad++; $display("FAIL lat_dout: got %h want 2200", bus.data_out); end
        step;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat4: got %b want 0", bus.out_valid); end
        total++; if (bus.data_out !== 14'h2200) begin bad++; $display("FAIL hold_dout: got %h want 2200", bus.data_out); end
    endtask

    task automatic test_saturation;
        run_one(27'sh0080000, 8'd20);
        total++; if (bus.data_out !== 14'h3FFF) begin bad++; $display("FAIL sat_pos: got %h want 3fff", bus.data_out); end
        total++; if (bus.sat_flag !== 1'b1) begin bad++; $display("FAIL sat_set: got %b want 1", bus.sat_flag); end
        bus.sat_clr = 1'b1;
        step;
        bus.sat_clr = 1'b0;
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clr: got %b want 0", bus.sat_flag); end
        bus.sat_clr = 1'b1; bus.in_valid = 1'b1; bus.data_in = 27'sh0080000; bus.shift = 8'd20;
        step;
        bus.sat_clr = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.sat_flag !== 1'b1) begin bad++; $display("FAIL sat_wins: got %b want 1", bus.sat_flag); end
        run_one(-27'sd12288, 8'd14);
        total++; if (bus.data_out !== 14'h0000) begin bad++; $display("FAIL sat_neg: got %h want 0000", bus.data_out); end
        bus.sat_clr = 1'b1;
        step;
        bus.sat_clr = 1'b0;
    endtask

    task automatic test_rounding;
        run_one(27'sd3, 8'd15);
        total++; if (bus.data_out !== 14'h2002) begin bad++; $display("FAIL rnd_p3: got %h want 2002", bus.data_out); end
        run_one(-27'sd3, 8'd15);
        total++; if (bus.data_out !== 14'h1FFF) begin bad++; $display("FAIL rnd_m3: got %h want 1fff", bus.data_out); end
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL rnd_nosat: got %b want 0", bus.sat_flag); end
        run_one(27'sh0000100, 8'd5);
        total++; if (bus.data_out !== 14'h2100) begin bad++; $display("FAIL clamp_lo: got %h want 2100", bus.data_out); end
        run_one(27'sh0000100, 8'd14);
        total++; if (bus.data_out !== 14'h2100) begin bad++; $display("FAIL sh14: got %h want 2100", bus.data_out); end
        run_one(27'sh0400000, 8'd40);
        total++; if (bus.data_out !== 14'h2200) begin bad++; $display("FAIL clamp_hi: got %h want 2200", bus.data_out); end
        run_one(27'sh0003FFF, 8'd15);
        total++; if (bus.data_out !== 14'h3FFF) begin bad++; $display("FAIL rnd_ovf: got %h want 3fff", bus.data_out); end
        total++; if (bus.sat_flag !== 1'b1) begin bad++; $display("FAIL rnd_ovf_flag: got %b want 1", bus.sat_flag); end
    endtask

    // Stage-1 value 1600; each gain step is worth 100 codes.
    task automatic test_ramp_profile;
        int g;
        logic [13:0] exp_code;
        do_reset;
        bus.data_in = 27'sd1600; bus.shift = 8'd14; bus.in_valid = 1'b1;
        for (int j = 0; j <= 36; j++) begin
            bus.tx = (j < 18);
            step;
            if (j >= 2) begin
                int k;
                k = j - 2;
                g = (k <= 16) ? k : (k <= 18) ? 16 : 34 - k;
                exp_code = 14'(32'h2000 + 100 * g);
                total++; if (bus.data_out !== exp_code || bus.out_valid !== 1'b1) begin
                    bad++; $display("FAIL ramp[%0d]: got %h/%b want %h/1", k, bus.data_out, bus.out_valid, exp_code);
                end
            end
        end
        bus.in_valid = 1'b0;
        total++; if (bus.tx_active !== 1'b0) begin bad++; $display("FAIL ramp_end_txa: got %b want 0", bus.tx_active); end
        total++; if (bus.data_out !== 14'h2000) begin bad++; $display("FAIL ramp_end_dout: got %h want 2000", bus.data_out); end
    endtask

    task automatic test_back_to_back;
        int g;
        logic [13:0] exp_code;
        do_reset;
        bus.data_in = 27'sd1600; bus.shift = 8'd14; bus.in_valid = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            bus.tx = !(j >= 8 && j <= 10);
            step;
            total++; if (bus.ramp_busy !== 1'b1) begin bad++; $display("FAIL rev_busy[%0d]: got %b want 1", j, bus.ramp_busy); end
            if (j >= 2) begin
                int k;
                k = j - 2;
                g = (k <= 8) ? k : (k <= 11) ? 16 - k : k - 6;
                exp_code = 14'(32'h2000 + 100 * g);
                total++; if (bus.data_out !== exp_code) begin
                    bad++; $display("FAIL rev[%0d]: got %h want %h", k, bus.data_out, exp_code);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.tx = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in = '0;
        bus.shift = 8'd27;
        bus.sat_clr = 1'b0;
        test_reset;
        test_latency;
        test_saturation;
        test_rounding;
        test_ramp_profile;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
